lsu: RTL and testbench
======================

# lsu

Load/store unit that sits directly downstream of the single-cycle core's execute stage and supplies the load result its write-back path expects. It takes the computed effective address, funct3 and store data, and runs one valid/ready transaction on the data-memory bus. It stalls the core until the access finishes, then returns sign/zero-extended load data or an exception code. At most one access is outstanding.

## Interface
Parameters:
- `TIMEOUT_CYC`, 255: maximum number of cycles spent in WAIT before a timeout exception.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core requests an access (load | store); held until `done`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I load/store funct3.
- `req_addr`  in  32  effective byte address (rs1 + imm).
- `req_wdata`  in  32  rs2 data for stores.
- `stall`  out  1  freezes the core's PC and register-file write.
- `done`  out  1  one-cycle pulse: access finished; `ld_data` and `exc_code` are valid.
- `ld_data`  out  32  extended load result; holds its value until the next load's `done`.
- `exc_code`  out  3  0 none, 1 misaligned, 2 illegal funct3, 3 bus error, 4 timeout.
- `mem_req_valid`  out  1  request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  word address; `{addr[31:2], 2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rsp_valid`  in  1  response valid; always accepted.
- `mem_rsp_data`  in  32  read word.
- `mem_rsp_err`  in  1  bus error, qualified by `mem_rsp_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, `req_valid`=1: latch addr, funct3, store flag and aligned wdata/be.
  - Legal and aligned: go to REQ.
  - Illegal funct3: go to DONE with code 2. Illegal means loads 3/6/7; stores 3–7.
  - Misaligned: go to DONE with code 1, and no bus transaction is issued. Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠0.
- REQ: `mem_req_valid`=1, with addr/we/be/wdata stable until `mem_req_ready`, then go to WAIT. Clear the timeout counter.
- WAIT: the counter increments each cycle.
  - `mem_rsp_valid`: go to DONE. Code 3 if `mem_rsp_err`, else 0. For loads without error, register the extracted data into `ld_data`.
  - Counter reaches `TIMEOUT_CYC`-1 without a response: go to DONE with code 4.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Stall: `stall` = `req_valid` & (state≠DONE).
  - The core advances on the edge where `done`=1.
  - A back-to-back access is accepted in the following IDLE cycle.
- Lane rules (off = addr[1:0]):
  - SB: be = 1<<off, wdata = {4{b}}.
  - SH: be = 3<<off, wdata = {2{h}}.
  - SW: be = 4'hF.
  - LB/LBU: byte off of the response, sign/zero extended.
  - LH/LHU: halfword off[1], sign/zero extended.
  - LW: word unchanged.
- Stores never modify `ld_data`. Loads that end with code 1–4 leave `ld_data` unchanged.
- `mem_rsp_valid` outside WAIT is dropped. This covers late responses after a timeout.
- Reset, including mid-transaction:
  - Async return to IDLE; the counter is cleared.
  - Outputs go to 0: `stall`, `done`, `ld_data`, `exc_code`, `mem_req_valid`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`.
  - `mem_req_valid` deasserts combinationally with `rst`.

## Timing
- Minimum access latency: 4 cycles.
  - c0: IDLE, accept.
  - c1: REQ with ready=1.
  - c2: WAIT with rsp_valid=1.
  - c3: DONE.
  - `stall`=1 during c0–c2.
- Each cycle of ready=0 or rsp delay adds one cycle.
- Misaligned or illegal requests: 2 cycles (IDLE→DONE).
- Timeout: `done` asserts `TIMEOUT_CYC`+2 cycles after acceptance when ready is immediate.
- `done`, `exc_code` and `ld_data` are all registered outputs.
- `mem_*` request outputs come from registers.
- `mem_req_valid` is a decode of the REQ state.

## Structure
- Shared package `def.sv` holds:
  - funct3 constants: `F3_LB/LH/LW/LBU/LHU/SB/SH/SW`.
  - the `exc_code` enum.
  - the `lsu_state_t` enum.
- Sub-module `ld_align`: combinational extraction and extension of the read word from funct3 and off.
- Store lane/byte-enable generation stays inline.

## Test plan
- LW at 0x100, ready and response immediate, rsp_data=0xDEADBEEF -> `done` in c3, `ld_data`=0xDEADBEEF, code 0, `stall` high for exactly 3 cycles.
- LB/LBU at 0x103 with rsp_data=0x80FF0102 -> `ld_data`=0xFFFFFF80 for LB and 0x00000080 for LBU. LH at 0x102 -> 0xFFFF80FF.
- SH at 0x206 with wdata=0x1234ABCD -> `mem_addr`=0x204, be=4'b1100, `mem_wdata`=0xABCDABCD, `mem_we`=1; `ld_data` unchanged.
- LW at 0x101 -> code 1 after 2 cycles with no `mem_req_valid`. Load with funct3=3 -> code 2.
- Ready held low 5 cycles, then a response with err=1 -> request stays stable throughout, code 3. With `TIMEOUT_CYC`=8 and no response -> code 4; a later stray rsp_valid is ignored.
- `rst` low during WAIT -> immediately `mem_req_valid`=0, `stall`=0, all outputs 0. After release the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, exception codes,
// FSM states, the memory request payload and funct3 legality helpers.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = XLEN / 8;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    EXC_NONE     = 3'd0,
    EXC_MISALIGN = 3'd1,
    EXC_ILLEGAL  = 3'd2,
    EXC_BUS      = 3'd3,
    EXC_TIMEOUT  = 3'd4
  } exc_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BEW-1:0]  be;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Size lives in funct3[1:0] for both loads and stores.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd1:    return off[0];
      2'd2:    return off != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Picks the addressed byte/halfword out of a read word and sign/zero extends it.
module ld_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    data_c   = word;
    case (funct3)
      F3_LB:   data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_c = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data_c = {24'd0, byte_sel};
      F3_LHU:  data_c = {16'd0, half_sel};
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding valid/ready access on the data-memory bus,
// stalling the core until the access completes or raises an exception.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] ld_data,
  output logic [2:0]      exc_code,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [BEW-1:0]  mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  lsu_state_t      state_q, state_d;
  exc_code_t       exc_q, exc_d;
  logic [CW-1:0]   cnt_q;
  logic            store_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  mem_req_t        mem_q, req_c;
  logic [XLEN-1:0] ld_c;
  logic            accept_c;

  assign accept_c = (state_q == ST_IDLE) && req_valid;

  // Word address plus lane-replicated store data and byte enables.
  always_comb begin
    req_c.we    = req_store;
    req_c.addr  = {req_addr[XLEN-1:2], 2'b00};
    req_c.be    = 4'hF;
    req_c.wdata = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        req_c.be    = 4'(4'b0001 << req_addr[1:0]);
        req_c.wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_c.be    = 4'(4'b0011 << req_addr[1:0]);
        req_c.wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    exc_d   = EXC_NONE;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!f3_legal(req_store, req_funct3)) begin
            state_d = ST_DONE;
            exc_d   = EXC_ILLEGAL;
          end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
            state_d = ST_DONE;
            exc_d   = EXC_MISALIGN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = ST_DONE;
          exc_d   = mem_rsp_err ? EXC_BUS : EXC_NONE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d = ST_DONE;
          exc_d   = EXC_TIMEOUT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  ld_align u_ld_align (
    .funct3 (f3_q),
    .off    (off_q),
    .word   (mem_rsp_data),
    .data_c (ld_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done    <= 1'b0;
      exc_q   <= EXC_NONE;
      ld_data <= '0;
      cnt_q   <= '0;
      store_q <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      mem_q   <= '0;
    end else begin
      done <= (state_d == ST_DONE);
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) exc_q <= exc_d;
      if (accept_c) begin
        store_q <= req_store;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        mem_q   <= req_c;
      end
      if (state_q == ST_REQ)       cnt_q <= '0;
      else if (state_q == ST_WAIT) cnt_q <= cnt_q + CW'(1);
      // Only error-free load responses update the write-back value.
      if ((state_q == ST_WAIT) && mem_rsp_valid && !mem_rsp_err && !store_q)
        ld_data <= ld_c;
    end
  end

  assign exc_code      = exc_q;
  assign mem_we        = mem_q.we;
  assign mem_addr      = mem_q.addr;
  assign mem_be        = mem_q.be;
  assign mem_wdata     = mem_q.wdata;
  assign mem_req_valid = rst && (state_q == ST_REQ);
  assign stall         = rst && req_valid && (state_q != ST_DONE);

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small negedge-driven memory responder.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk, rst;
  logic        req_valid, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done;
  logic [31:0] ld_data;
  logic [2:0]  exc_code;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;

  int tests = 0;
  int fails = 0;

  // memory model knobs and observations
  int          ready_delay = 0, rsp_delay = 0;
  logic        rsp_err = 1'b0, no_rsp = 1'b0, stray = 1'b0;
  logic [31:0] rsp_word = 32'h0;
  int          rdy_cnt = 0, rsp_cnt = 0, stable_bad = 0;
  logic        accept_next = 1'b0, pending = 1'b0, snap_valid = 1'b0;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_be;
  logic        snap_we;

  // access results
  int          cyc, stall_cyc, reqv_cyc;
  logic        stall_at_done;
  logic [2:0]  exc_seen;

  lsu #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .ld_data(ld_data), .exc_code(exc_code),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      if (accept_next) begin
        pending     = 1'b1;
        rsp_cnt     = 0;
        accept_next = 1'b0;
      end
      if (pending) begin
        if (rsp_cnt == rsp_delay) begin
          if (!no_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_err   = rsp_err;
            mem_rsp_data  = rsp_word;
          end
          pending = 1'b0;
        end else begin
          rsp_cnt++;
        end
      end
      if (stray) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5555_5555;
      end
      if (mem_req_valid) begin
        if (!snap_valid) begin
          snap_valid = 1'b1;
          snap_addr  = mem_addr;
          snap_be    = mem_be;
          snap_wdata = mem_wdata;
          snap_we    = mem_we;
        end else if ({snap_we, snap_addr, snap_be, snap_wdata} !==
                     {mem_we, mem_addr, mem_be, mem_wdata}) begin
          stable_bad++;
        end
        if (rdy_cnt == ready_delay) begin
          mem_req_ready = 1'b1;
          accept_next   = 1'b1;
        end else begin
          mem_req_ready = 1'b0;
          rdy_cnt++;
        end
      end else begin
        mem_req_ready = 1'b0;
        rdy_cnt       = 0;
        snap_valid    = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until done (bounded), then release it.
  task automatic access(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    cyc = 0; stall_cyc = 0; reqv_cyc = 0;
    #1;
    while (!done && cyc < 200) begin
      if (stall) stall_cyc++;
      if (mem_req_valid) reqv_cyc++;
      cyc++;
      @(posedge clk); #1;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    stall_at_done = stall;
    exc_seen      = exc_code;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst stall",   32'(stall), 32'd0);
    chk("rst done",    32'(done), 32'd0);
    chk("rst ld_data", ld_data, 32'h0);
    chk("rst exc",     32'(exc_code), 32'd0);
    chk("rst reqv",    32'(mem_req_valid), 32'd0);
    chk("rst addr",    mem_addr, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // LW, zero-wait bus
    rsp_word = 32'hDEAD_BEEF;
    access("lw", 1'b0, F3_LW, 32'h100, 32'h0);
    chk("lw cycles",      32'(cyc), 32'd3);
    chk("lw stall cycles", 32'(stall_cyc), 32'd3);
    chk("lw stall@done",  32'(stall_at_done), 32'd0);
    chk("lw exc",         32'(exc_seen), 32'd0);
    chk("lw data",        ld_data, 32'hDEAD_BEEF);
    chk("lw addr",        32'(snap_addr), 32'h100);
    chk("lw be",          32'(snap_be), 32'hF);

    // sub-word loads
    rsp_word = 32'h80FF_0102;
    access("lb", 1'b0, F3_LB, 32'h103, 32'h0);
    chk("lb data", ld_data, 32'hFFFF_FF80);
    access("lbu", 1'b0, F3_LBU, 32'h103, 32'h0);
    chk("lbu data", ld_data, 32'h0000_0080);
    access("lh", 1'b0, F3_LH, 32'h102, 32'h0);
    chk("lh data", ld_data, 32'hFFFF_80FF);
    access("lhu", 1'b0, F3_LHU, 32'h100, 32'h0);
    chk("lhu data", ld_data, 32'h0000_0102);

    // stores
    access("sh", 1'b1, F3_SH, 32'h206, 32'h1234_ABCD);
    chk("sh exc",   32'(exc_seen), 32'd0);
    chk("sh addr",  snap_addr, 32'h204);
    chk("sh be",    32'(snap_be), 32'hC);
    chk("sh wdata", snap_wdata, 32'hABCD_ABCD);
    chk("sh we",    32'(snap_we), 32'd1);
    chk("sh ld_data", ld_data, 32'h0000_0102);
    access("sb", 1'b1, F3_SB, 32'h201, 32'h0000_00EF);
    chk("sb be",    32'(snap_be), 32'h2);
    chk("sb wdata", snap_wdata, 32'hEFEF_EFEF);

    // misaligned and illegal
    access("lw mis", 1'b0, F3_LW, 32'h101, 32'h0);
    chk("mis cycles", 32'(cyc), 32'd1);
    chk("mis exc",    32'(exc_seen), 32'd1);
    chk("mis reqv",   32'(reqv_cyc), 32'd0);
    chk("mis ld_data", ld_data, 32'h0000_0102);
    access("ld f3=3", 1'b0, 3'd3, 32'h100, 32'h0);
    chk("ill ld exc",  32'(exc_seen), 32'd2);
    chk("ill ld reqv", 32'(reqv_cyc), 32'd0);
    access("st f3=4", 1'b1, 3'd4, 32'h100, 32'h0);
    chk("ill st exc",  32'(exc_seen), 32'd2);

    // slow ready, bus error
    ready_delay = 5; rsp_err = 1'b1; stable_bad = 0;
    access("lw err", 1'b0, F3_LW, 32'h104, 32'h0);
    chk("err cycles", 32'(cyc), 32'd8);
    chk("err exc",    32'(exc_seen), 32'd3);
    chk("err stable", 32'(stable_bad), 32'd0);
    chk("err addr",   snap_addr, 32'h104);
    chk("err ld_data", ld_data, 32'h0000_0102);
    ready_delay = 0; rsp_err = 1'b0;

    // timeout, then stray responses
    no_rsp = 1'b1;
    access("lw to", 1'b0, F3_LW, 32'h108, 32'h0);
    chk("to cycles", 32'(cyc), 32'd10);
    chk("to exc",    32'(exc_seen), 32'd4);
    chk("to ld_data", ld_data, 32'h0000_0102);
    no_rsp = 1'b0;
    stray  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stray done", 32'(done), 32'd0);
    end
    stray = 1'b0;
    chk("stray ld_data", ld_data, 32'h0000_0102);

    // reset while waiting for a response
    rsp_delay = 10;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = F3_LW; req_addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-rst stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid-rst reqv",  32'(mem_req_valid), 32'd0);
    chk("mid-rst stall", 32'(stall), 32'd0);
    chk("mid-rst done",  32'(done), 32'd0);
    chk("mid-rst ld",    ld_data, 32'h0);
    chk("mid-rst exc",   32'(exc_code), 32'd0);
    chk("mid-rst bus",   mem_addr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'h0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post-rst done", 32'(done), 32'd0);
    rsp_delay = 0;
    rsp_word  = 32'h0BAD_F00D;
    access("lw post", 1'b0, F3_LW, 32'h300, 32'h0);
    chk("post cycles", 32'(cyc), 32'd3);
    chk("post exc",    32'(exc_seen), 32'd0);
    chk("post data",   ld_data, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
